logic_pod_chunk_packer: RTL

//  Downstream of the logic pod compression engine. Takes its stream of 17-bit chunks ({format, data[15:0]}, at most one
//  per clock, no backpressure) and bit-packs them densely into OUT_WIDTH-bit words for the capture memory FIFO.

---
 rtl/logic_pod_chunk_packer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/logic_pod_chunk_packer.sv
// Densely bit-packs 17-bit compressor chunks into OUT_WIDTH-bit words, with end-of-capture flush and overflow detection.
// Optional statistics counters are enabled by defining LOGIC_POD_PACKER_STATS_EN.
module logic_pod_chunk_packer #(
  parameter int OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_format,
  input  logic [15:0]          in_data,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 overflow
`ifdef LOGIC_POD_PACKER_STATS_EN
  ,
  output logic [31:0]          stat_chunks,
  output logic [31:0]          stat_words
`endif
);

  localparam int ACC_W  = OUT_WIDTH + 16;
  localparam int FILL_W = $clog2(OUT_WIDTH + 17);

  typedef enum logic [1:0] {IDLE, RUN, PAD, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [OUT_WIDTH-1:0] data_p1, data_d;
  logic                 vld_p1, vld_d;
  logic                 last_p1, last_d;
  logic                 overflow_q, overflow_d;
  logic                 flush_done_q, flush_done_d;

  logic [16:0]          chunk;
  logic [ACC_W-1:0]     merged;
  logic [FILL_W-1:0]    fill_sum;
  logic                 completes;
  logic                 accept;
  logic                 hold_free;
  logic                 chunk_ok;

  always_comb begin
    chunk     = {in_format, in_data};
    merged    = acc_q | (ACC_W'(chunk) << fill_q);
    fill_sum  = fill_q + FILL_W'(17);
    completes = (fill_sum >= FILL_W'(OUT_WIDTH));
    accept    = vld_p1 && out_ready;
    hold_free = !vld_p1 || out_ready;
    chunk_ok  = in_valid && (state_q == IDLE || state_q == RUN) && (!completes || hold_free);
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    data_d       = data_p1;
    vld_d        = vld_p1 && !out_ready;
    last_d       = accept ? 1'b0 : last_p1;
    overflow_d   = overflow_q || (in_valid && !chunk_ok);
    flush_done_d = accept && last_p1;

    case (state_q)
      IDLE, RUN: begin
        if (chunk_ok) begin
          state_d = RUN;
          if (completes) begin
            data_d = merged[OUT_WIDTH-1:0];
            vld_d  = 1'b1;
            last_d = 1'b0;
            acc_d  = merged >> OUT_WIDTH;
            fill_d = fill_sum - FILL_W'(OUT_WIDTH);
          end else begin
            acc_d  = merged;
            fill_d = fill_sum;
          end
        end
        // Flush acts on the post-chunk state; an empty accumulator with a word in hand reuses that word as the last.
        if (flush) begin
          if (fill_d == '0 && vld_d) begin
            last_d  = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        if (hold_free) begin
          data_d  = acc_q[OUT_WIDTH-1:0];
          vld_d   = 1'b1;
          last_d  = 1'b1;
          acc_d   = '0;
          fill_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && last_p1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: accumulator and one-entry output holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      fill_q       <= '0;
      data_p1      <= '0;
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
      overflow_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      data_p1      <= data_d;
      vld_p1       <= vld_d;
      last_p1      <= last_d;
      overflow_q   <= overflow_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign out_last   = last_p1;
  assign overflow   = overflow_q;
  assign flush_done = flush_done_q;

`ifdef LOGIC_POD_PACKER_STATS_EN
  logic [31:0] chunks_q;
  logic [31:0] words_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chunks_q <= '0;
      words_q  <= '0;
    end else begin
      if (chunk_ok && chunks_q != 32'hFFFF_FFFF) chunks_q <= chunks_q + 32'd1;
      if (accept && words_q != 32'hFFFF_FFFF)    words_q  <= words_q + 32'd1;
    end
  end

  assign stat_chunks = chunks_q;
  assign stat_words  = words_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
